// File: rtl/alu_param.sv
// Parametrised calculator ALU: add/sub in one step, iterative Booth multiply
// and restoring divide, started by a rising edge of parser_done.
module alu_param #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           dtype,
  input  logic [4:0]           operator,
  input  logic [WIDTH-1:0]     src1,
  input  logic [WIDTH-1:0]     src2,
  input  logic                 parser_done,
  output logic                 busy,
  output logic                 alu_done,
  output logic                 err,
  output logic [2*WIDTH-1:0]   calc_res
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MUL = 5'h03;
  localparam logic [4:0] OP_DIV = 5'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic               pd_q;
  logic               start;
  logic               in_signed;
  logic               in_illegal;

  logic               is_signed;
  logic               illegal_r;
  logic [4:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [CW-1:0]      cnt;

  logic [WIDTH+1:0]   mul_acc;
  logic [WIDTH+1:0]   mul_m;
  logic [WIDTH:0]     mul_q;
  logic               mul_qm1;
  logic [WIDTH+1:0]   booth_sum;
  logic [WIDTH+1:0]   acc_nxt;
  logic [WIDTH:0]     q_nxt;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_dvs;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   fix_q;
  logic [WIDTH-1:0]   fix_r;

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] calc_val;
  logic               calc_err;

  assign start      = (state == S_IDLE) && parser_done && !pd_q;
  assign in_signed  = (dtype == 4'h1);
  assign in_illegal = !((dtype == 4'h1) || (dtype == 4'h2)) ||
                      !((operator == OP_ADD) || (operator == OP_SUB) ||
                        (operator == OP_MUL) || (operator == OP_DIV));

  // One radix-2 Booth step; acc carries a guard bit so adding/subtracting
  // the extended multiplicand can never overflow.
  always_comb begin
    booth_sum = mul_acc;
    case ({mul_q[0], mul_qm1})
      2'b01:   booth_sum = mul_acc + mul_m;
      2'b10:   booth_sum = mul_acc - mul_m;
      default: booth_sum = mul_acc;
    endcase
    acc_nxt  = {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
    q_nxt    = {booth_sum[0], mul_q[WIDTH:1]};
    mul_prod = {acc_nxt[WIDTH-2:0], q_nxt};
  end

  always_comb begin
    div_shift = {div_rem, div_quo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, div_dvs});
    rem_nxt   = div_ge ? WIDTH'(div_shift - {1'b0, div_dvs}) : div_shift[WIDTH-1:0];
    quo_nxt   = {div_quo[WIDTH-2:0], div_ge};
    a_mag     = (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
    b_mag     = (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;
    fix_q     = (is_signed && (a_r[WIDTH-1] ^ b_r[WIDTH-1])) ? -div_quo : div_quo;
    fix_r     = (is_signed && a_r[WIDTH-1]) ? -div_rem : div_rem;
  end

  // Single-step results: add/sub at full result width, or an error code.
  always_comb begin
    ext_a    = is_signed ? {{WIDTH{a_r[WIDTH-1]}}, a_r} : {{WIDTH{1'b0}}, a_r};
    ext_b    = is_signed ? {{WIDTH{b_r[WIDTH-1]}}, b_r} : {{WIDTH{1'b0}}, b_r};
    calc_val = '0;
    calc_err = 1'b0;
    if (illegal_r) begin
      calc_err = 1'b1;
    end else if (op_r == OP_DIV) begin
      calc_err = 1'b1;
      calc_val = {a_r, {WIDTH{1'b1}}};
    end else if (op_r == OP_SUB) begin
      calc_val = ext_a - ext_b;
    end else begin
      calc_val = ext_a + ext_b;
    end
  end

  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    alu_done   = (state == S_DONE);
    case (state)
      S_IDLE: begin
        if (start) begin
          if (in_illegal)
            state_next = S_CALC;
          else if (operator == OP_MUL)
            state_next = S_MUL;
          else if ((operator == OP_DIV) && (src2 != '0))
            state_next = S_DIV;
          else
            state_next = S_CALC;
        end
      end
      S_CALC:  state_next = S_DONE;
      S_MUL:   if (cnt == CW'(WIDTH)) state_next = S_DONE;
      S_DIV:   if (cnt == CW'(WIDTH)) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath. The first DIV cycle loads magnitudes; the remaining WIDTH
  // cycles are restoring steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pd_q      <= 1'b1;
      err       <= 1'b0;
      calc_res  <= '0;
      is_signed <= 1'b0;
      illegal_r <= 1'b0;
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      cnt       <= '0;
      mul_acc   <= '0;
      mul_m     <= '0;
      mul_q     <= '0;
      mul_qm1   <= 1'b0;
      div_rem   <= '0;
      div_quo   <= '0;
      div_dvs   <= '0;
    end else begin
      state <= state_next;
      pd_q  <= parser_done;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_signed <= in_signed;
            illegal_r <= in_illegal;
            op_r      <= operator;
            a_r       <= src1;
            b_r       <= src2;
            err       <= 1'b0;
            cnt       <= '0;
            mul_acc   <= '0;
            mul_m     <= in_signed ? {{2{src1[WIDTH-1]}}, src1} : {2'b00, src1};
            mul_q     <= {in_signed & src2[WIDTH-1], src2};
            mul_qm1   <= 1'b0;
          end
        end
        S_CALC: begin
          calc_res <= calc_val;
          err      <= calc_err;
        end
        S_MUL: begin
          mul_acc <= acc_nxt;
          mul_q   <= q_nxt;
          mul_qm1 <= mul_q[0];
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(WIDTH))
            calc_res <= mul_prod;
        end
        S_DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == '0) begin
            div_rem <= '0;
            div_quo <= a_mag;
            div_dvs <= b_mag;
          end else begin
            div_rem <= rem_nxt;
            div_quo <= quo_nxt;
          end
        end
        S_FIX:   calc_res <= {fix_r, fix_q};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_param.sv
// Directed vector bench for alu_param (WIDTH=16): table-driven operations
// plus hand sequences for reset-held start, mid-multiply reset and illegal op.
module tb_alu_param;

  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic [3:0]     dtype;
  logic [4:0]     op;
  logic [W-1:0]   src1;
  logic [W-1:0]   src2;
  logic           parser_done;
  logic           busy;
  logic           alu_done;
  logic           err;
  logic [2*W-1:0] calc_res;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [3:0]  dtype;
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[18];

  alu_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .dtype       (dtype),
    .operator    (op),
    .src1        (src1),
    .src2        (src2),
    .parser_done (parser_done),
    .busy        (busy),
    .alu_done    (alu_done),
    .err         (err),
    .calc_res    (calc_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issue one operation, scramble inputs after capture, measure latency and
  // confirm a single done pulse; a long parser_done hold must not retrigger.
  task automatic applyStimulus(input vec_t v, input string name);
    int   lat;
    logic saw;
    @(negedge clk);
    parser_done = 1'b0;
    @(negedge clk);
    dtype = v.dtype; op = v.op; src1 = v.a; src2 = v.b;
    parser_done = 1'b1;
    @(posedge clk); #1;
    checkOutput({name, " busy_at_capture"}, busy, 1);
    dtype = 4'hF; op = 5'h1F; src1 = ~v.a; src2 = ~v.b;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat >= v.hold) parser_done = 1'b0;
      if (alu_done) break;
    end
    checkOutput({name, " latency"}, lat, v.lat);
    checkOutput({name, " calc_res"}, calc_res, v.res);
    checkOutput({name, " err"}, err, v.err);
    @(posedge clk); #1;
    lat++;
    checkOutput({name, " done_single_pulse"}, alu_done, 0);
    checkOutput({name, " busy_cleared"}, busy, 0);
    saw = 1'b0;
    while (lat < v.hold) begin
      @(posedge clk); #1;
      lat++;
      if (busy) saw = 1'b1;
    end
    parser_done = 1'b0;
    if (v.hold > v.lat + 1) checkOutput({name, " no_retrigger"}, saw, 0);
  endtask

  initial begin
    logic saw;
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{4'h2, 5'h01, 16'h0007, 16'h0002, 32'h00000009, 1'b0, 1, 3};
    vecs[1]  = '{4'h1, 5'h02, 16'h0008, 16'h0004, 32'h00000004, 1'b0, 1, 10};
    vecs[2]  = '{4'h1, 5'h02, 16'h0004, 16'h0008, 32'hFFFFFFFC, 1'b0, 1, 1};
    vecs[3]  = '{4'h2, 5'h02, 16'h0004, 16'h0008, 32'hFFFFFFFC, 1'b0, 1, 1};
    vecs[4]  = '{4'h2, 5'h03, 16'h0007, 16'h0003, 32'h00000015, 1'b0, 17, 10};
    vecs[5]  = '{4'h2, 5'h03, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 17, 1};
    vecs[6]  = '{4'h1, 5'h03, 16'h0006, 16'hFFFB, 32'hFFFFFFE2, 1'b0, 17, 1};
    vecs[7]  = '{4'h1, 5'h03, 16'h8000, 16'h8000, 32'h40000000, 1'b0, 17, 1};
    vecs[8]  = '{4'h1, 5'h04, 16'hFFF9, 16'h0002, 32'hFFFFFFFD, 1'b0, 18, 1};
    vecs[9]  = '{4'h2, 5'h04, 16'h0064, 16'h0000, 32'h0064FFFF, 1'b1, 1, 1};
    vecs[10] = '{4'h1, 5'h04, 16'h8000, 16'hFFFF, 32'h00008000, 1'b0, 18, 1};
    vecs[11] = '{4'h1, 5'h04, 16'h0007, 16'hFFFE, 32'h0001FFFD, 1'b0, 18, 1};
    vecs[12] = '{4'h3, 5'h01, 16'h0001, 16'h0001, 32'h00000000, 1'b1, 1, 1};
    vecs[13] = '{4'h1, 5'h01, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFE, 1'b0, 1, 1};
    vecs[14] = '{4'h2, 5'h01, 16'hFFFF, 16'hFFFF, 32'h0001FFFE, 1'b0, 1, 1};
    vecs[15] = '{4'h1, 5'h02, 16'h8000, 16'h0001, 32'hFFFF7FFF, 1'b0, 1, 1};
    vecs[16] = '{4'h2, 5'h02, 16'h0000, 16'hFFFF, 32'hFFFF0001, 1'b0, 1, 1};
    vecs[17] = '{4'h2, 5'h04, 16'h0064, 16'h0007, 32'h0002000E, 1'b0, 18, 1};

    rst = 1'b1; parser_done = 1'b1;
    dtype = 4'h2; op = 5'h01; src1 = 16'h0001; src2 = 16'h0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset alu_done", alu_done, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset calc_res", calc_res, 0);
    saw = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy || alu_done) saw = 1'b1;
    end
    checkOutput("held_through_reset no_start", saw, 0);

    for (int i = 0; i < 18; i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset during the fifth multiply step with parser_done held high.
    @(negedge clk);
    parser_done = 1'b0;
    @(negedge clk);
    dtype = 4'h2; op = 5'h03; src1 = 16'h0007; src2 = 16'h0003;
    parser_done = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset busy_at_capture", busy, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset alu_done", alu_done, 0);
    checkOutput("midreset err", err, 0);
    checkOutput("midreset calc_res", calc_res, 0);
    saw = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (busy || alu_done) saw = 1'b1;
    end
    checkOutput("midreset no_activity", saw, 0);

    applyStimulus('{4'h2, 5'h07, 16'h0005, 16'h0003, 32'h00000000, 1'b1, 1, 1},
                  "illegal_op");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
